// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-key debouncer.
// Provides the channel FSM state encoding and the cnt_max() constant function.
package debounce_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  // Number of clk cycles in a window of ms milliseconds.
  function automatic int cnt_max(
    input int clk_hz,
    input int ms
  );
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounced key channel: synchronizer, restart-on-bounce timer, pulses.
// Ports: clk, rst (async, active-high), key_in raw key; key_level stable
// level, key_press/key_release 1-cycle pulses, key_busy while timing,
// key_long 1-cycle long-press pulse (only with DEBOUNCE_LONGPRESS_EN).
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int   CNT_MAX     = 8,
  parameter int   LONG_CNT    = 32,
  parameter logic IDLE_LEVEL  = 1'b1,
  parameter int   SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_busy,
  output logic key_long
);

  if (CNT_MAX < 2) begin : g_bad_cnt
    $error("debounce_chan: CNT_MAX must be >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounce_chan: SYNC_STAGES must be >= 2");
  end

  localparam int CW = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s;

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          level_q;
  logic          level_d;
  logic          press_q;
  logic          press_d;
  logic          rel_q;
  logic          rel_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], key_in};
  assign s      = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{IDLE_LEVEL}};
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      level_q <= IDLE_LEVEL;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  // Any return of s to the current level while counting restarts the window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (s != level_q) begin
          state_d = ST_COUNT;
          cnt_d   = '0;
        end
      end
      ST_COUNT: begin
        if (s == level_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          level_d = s;
          press_d = (s != IDLE_LEVEL);
          rel_d   = (s == IDLE_LEVEL);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = rel_q;
  assign key_busy    = (state_q == ST_COUNT);

`ifdef DEBOUNCE_LONGPRESS_EN

  if (LONG_CNT < 2) begin : g_bad_long
    $error("debounce_chan: LONG_CNT must be >= 2");
  end

  localparam int HW = (LONG_CNT > 2) ? $clog2(LONG_CNT) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CNT - 1);

  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
  logic          fired_q;
  logic          fired_d;
  logic          long_q;
  logic          long_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q  <= '0;
      fired_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      fired_q <= fired_d;
      long_q  <= long_d;
    end
  end

  // Counter saturates at HOLD_LAST; fired_q blocks a second pulse
  // until the key is released.
  always_comb begin
    hold_d  = hold_q;
    fired_d = fired_q;
    long_d  = 1'b0;
    if (press_d) begin
      hold_d  = '0;
      fired_d = 1'b0;
    end else if (level_q != IDLE_LEVEL) begin
      if (hold_q != HOLD_LAST) begin
        hold_d = hold_q + 1'b1;
      end else if (!fired_q) begin
        long_d  = 1'b1;
        fired_d = 1'b1;
      end
    end else begin
      hold_d  = '0;
      fired_d = 1'b0;
    end
  end

  assign key_long = long_q;

`else

  assign key_long = 1'b0;

`endif

endmodule

// File: rtl/debounce_multi.sv
// N-key push-button conditioner: per-key sync, debounce, press/release pulses.
// Ports: clk, rst (async, active-high), key_in[N_KEYS]; outputs key_level,
// key_press, key_release, key_busy, key_long (all N_KEYS wide).
// Macro DEBOUNCE_LONGPRESS_EN enables the per-key long-press pulse.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int   N_KEYS      = 4,
  parameter int   CLK_HZ      = 50_000_000,
  parameter int   DEBOUNCE_MS = 20,
  parameter logic IDLE_LEVEL  = 1'b1,
  parameter int   SYNC_STAGES = 2,
  parameter int   LONG_MS     = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_busy,
  output logic [N_KEYS-1:0] key_long
);

  localparam int CNT_MAX  = cnt_max(CLK_HZ, DEBOUNCE_MS);
  localparam int LONG_CNT = cnt_max(CLK_HZ, LONG_MS);

  for (genvar k = 0; k < N_KEYS; k++) begin : g_chan
    debounce_chan #(
      .CNT_MAX     (CNT_MAX),
      .LONG_CNT    (LONG_CNT),
      .IDLE_LEVEL  (IDLE_LEVEL),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .key_in      (key_in[k]),
      .key_level   (key_level[k]),
      .key_press   (key_press[k]),
      .key_release (key_release[k]),
      .key_busy    (key_busy[k]),
      .key_long    (key_long[k])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi (CNT_MAX=8, LONG_CNT=32, 4 keys).
// Table-driven vectors plus hand sequences for bounce, glitch, reset, hold.
module tb_debounce_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_in;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_busy;
  logic [3:0] key_long;

  int n_chk  = 0;
  int n_fail = 0;

  int press_n [4];
  int rel_n   [4];
  int long_n  [4];
  int both_n  = 0;

  debounce_multi #(
    .N_KEYS      (4),
    .CLK_HZ      (1000),
    .DEBOUNCE_MS (8),
    .IDLE_LEVEL  (1'b1),
    .SYNC_STAGES (2),
    .LONG_MS     (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_busy    (key_busy),
    .key_long    (key_long)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (key_press[i])   press_n[i]++;
      if (key_release[i]) rel_n[i]++;
      if (key_long[i])    long_n[i]++;
      if (key_press[i] && key_release[i]) both_n++;
    end
  end

  typedef struct {
    logic [3:0] key;
    int         cyc;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] bsy;
  } vec_t;

  vec_t tbl [12];

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int p0;
    int r0;
    int k;
    bit seen;

    for (int i = 0; i < 4; i++) begin
      press_n[i] = 0;
      rel_n[i]   = 0;
      long_n[i]  = 0;
    end

    tbl[0]  = '{4'hF,  2, 4'hF, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{4'hE, 10, 4'hF, 4'h0, 4'h0, 4'h1};
    tbl[2]  = '{4'hE,  1, 4'hE, 4'h1, 4'h0, 4'h0};
    tbl[3]  = '{4'hE,  1, 4'hE, 4'h0, 4'h0, 4'h0};
    tbl[4]  = '{4'hF, 10, 4'hE, 4'h0, 4'h0, 4'h1};
    tbl[5]  = '{4'hF,  1, 4'hF, 4'h0, 4'h1, 4'h0};
    tbl[6]  = '{4'hF,  1, 4'hF, 4'h0, 4'h0, 4'h0};
    tbl[7]  = '{4'h3, 10, 4'hF, 4'h0, 4'h0, 4'hC};
    tbl[8]  = '{4'h3,  1, 4'h3, 4'hC, 4'h0, 4'h0};
    tbl[9]  = '{4'h3,  1, 4'h3, 4'h0, 4'h0, 4'h0};
    tbl[10] = '{4'hF, 11, 4'hF, 4'h0, 4'hC, 4'h0};
    tbl[11] = '{4'hF,  2, 4'hF, 4'h0, 4'h0, 4'h0};

    rst    = 1'b1;
    key_in = 4'hF;
    tick(3);
    chk("rst_level", 32'(key_level), 32'hF);
    chk("rst_press", 32'(key_press), 32'h0);
    chk("rst_rel",   32'(key_release), 32'h0);
    chk("rst_busy",  32'(key_busy), 32'h0);
    chk("rst_long",  32'(key_long), 32'h0);
    rst = 1'b0;

    for (int v = 0; v < 12; v++) begin
      key_in = tbl[v].key;
      tick(tbl[v].cyc);
      chk($sformatf("v%0d_level", v), 32'(key_level), 32'(tbl[v].lvl));
      chk($sformatf("v%0d_press", v), 32'(key_press), 32'(tbl[v].prs));
      chk($sformatf("v%0d_rel", v),   32'(key_release), 32'(tbl[v].rel));
      chk($sformatf("v%0d_busy", v),  32'(key_busy), 32'(tbl[v].bsy));
      chk($sformatf("v%0d_long", v),  32'(key_long), 32'h0);
    end

    // Bounce on key 1: low 5, high 1, then low held.
    p0 = press_n[1];
    key_in = 4'hD;
    tick(5);
    key_in = 4'hF;
    tick(1);
    key_in = 4'hD;
    tick(10);
    chk("bounce_no_early_press", 32'(press_n[1]), 32'(p0));
    chk("bounce_level_hold", 32'(key_level[1]), 32'h1);
    tick(1);
    chk("bounce_level_fall", 32'(key_level[1]), 32'h0);
    chk("bounce_press", 32'(key_press), 32'h2);
    key_in = 4'hF;
    tick(12);
    chk("bounce_released", 32'(key_level[1]), 32'h1);

    // Long press on key 0.
    key_in = 4'hE;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      if (key_press[0]) seen = 1'b1;
    end
    chk("long_press_seen", 32'(seen), 32'h1);
    k = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(1);
      k++;
      if (key_long[0]) seen = 1'b1;
    end
`ifdef DEBOUNCE_LONGPRESS_EN
    chk("long_seen", 32'(seen), 32'h1);
    chk("long_delay", 32'(k), 32'd32);
    tick(28);
    chk("long_single", 32'(long_n[0]), 32'h1);
`else
    chk("long_absent", 32'(seen), 32'h0);
    tick(20);
    chk("long_count", 32'(long_n[0]), 32'h0);
`endif

    // Short high glitch while pressed: no release.
    r0 = rel_n[0];
    key_in = 4'hF;
    tick(3);
    key_in = 4'hE;
    tick(15);
    chk("glitch_no_rel", 32'(rel_n[0]), 32'(r0));
    chk("glitch_level", 32'(key_level[0]), 32'h0);
    key_in = 4'hF;
    tick(12);
    chk("final_rel", 32'(rel_n[0]), 32'(r0 + 1));
    chk("final_level", 32'(key_level), 32'hF);

    // Reset in the middle of a count.
    p0 = press_n[0];
    key_in = 4'hE;
    tick(6);
    chk("midrst_busy_before", 32'(key_busy[0]), 32'h1);
    rst = 1'b1;
    key_in = 4'hF;
    #2;
    chk("midrst_busy", 32'(key_busy), 32'h0);
    chk("midrst_level", 32'(key_level), 32'hF);
    tick(1);
    rst = 1'b0;
    tick(15);
    chk("midrst_no_press", 32'(press_n[0]), 32'(p0));
    chk("midrst_level_after", 32'(key_level), 32'hF);

    chk("never_both", 32'(both_n), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
